// File: rtl/yutorina_spm_arbiter.sv
// yutorina_spm_arbiter: shares the single-port SPM between fetch (read-only) and memory access (read/write).
module yutorina_spm_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_MEM_STREAK = 3
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_request,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_grant,
  output logic                  fetch_stall,
  output logic                  fetch_read_valid,
  output logic [DATA_WIDTH-1:0] fetch_read_data,
  input  logic                  mem_request,
  input  logic                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_grant,
  output logic                  mem_read_valid,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [ADDR_WIDTH-1:0] spm_address,
  output logic                  spm_write_enable,
  output logic [DATA_WIDTH-1:0] spm_write_data,
  input  logic [DATA_WIDTH-1:0] spm_read_data
);
  logic [3:0] streak;
  logic       starved;
  // Grants are gated by reset so nothing reaches the SPM while reset is held.
  always_comb begin
    starved = streak == 4'(MAX_MEM_STREAK);
    mem_grant = reset & mem_request & ~(fetch_request & starved);
    fetch_grant = reset & fetch_request & ~mem_grant;
    fetch_stall = reset & fetch_request & ~fetch_grant;
    spm_address = mem_grant ? mem_address : fetch_grant ? fetch_address : '0;
    spm_write_enable = mem_grant & mem_write_enable;
    spm_write_data = mem_grant ? mem_write_data : '0;
  end
  assign fetch_read_data = spm_read_data;
  assign mem_read_data = spm_read_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      streak <= '0;
      fetch_read_valid <= 1'b0;
      mem_read_valid <= 1'b0;
    end else begin
      streak <= (fetch_grant | ~fetch_request) ? '0 : (mem_grant & ~starved) ? streak + 4'd1 : streak;
      fetch_read_valid <= fetch_grant;
      mem_read_valid <= mem_grant & ~mem_write_enable;
    end
endmodule

// File: tb/tb_yutorina_spm_arbiter.sv
// tb_yutorina_spm_arbiter: randomized scoreboard bench against a queue-based reference of the arbiter.
module tb_yutorina_spm_arbiter;
  localparam int MAX = 3;
  logic clock, reset;
  logic fetch_request, fetch_grant, fetch_stall, fetch_read_valid;
  logic [11:0] fetch_address;
  logic [31:0] fetch_read_data;
  logic mem_request, mem_write_enable, mem_grant, mem_read_valid;
  logic [11:0] mem_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic [11:0] spm_address;
  logic spm_write_enable;
  logic [31:0] spm_write_data, spm_read_data;

  yutorina_spm_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MAX_MEM_STREAK(MAX)) dut (
    .clock(clock), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address), .fetch_grant(fetch_grant),
    .fetch_stall(fetch_stall), .fetch_read_valid(fetch_read_valid), .fetch_read_data(fetch_read_data),
    .mem_request(mem_request), .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_grant(mem_grant), .mem_read_valid(mem_read_valid),
    .mem_read_data(mem_read_data), .spm_address(spm_address), .spm_write_enable(spm_write_enable),
    .spm_write_data(spm_write_data), .spm_read_data(spm_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SPM macro: unwritten words read back as address + 0x100.
  logic [31:0] spm_mem [0:4095];
  bit spm_wr [0:4095];
  always @(posedge clock) begin
    if (spm_write_enable) begin
      spm_mem[spm_address] <= spm_write_data;
      spm_wr[spm_address] <= 1'b1;
    end
    spm_read_data <= spm_wr[spm_address] ? spm_mem[spm_address] : 32'(spm_address) + 32'h100;
  end

  int vectors = 0, miscompares = 0;
  int waited = 0, stall_cnt = 0;
  bit pfg = 0, pmg = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] fq [$], mq [$];

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic [31:0] ref_rd(logic [11:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'(a) + 32'h100;
  endfunction

  // Monitor: every registered valid must match the oldest outstanding expected read.
  always @(posedge clock) begin
    #1;
    if (fetch_read_valid) begin
      if (fq.size() == 0) chk("fetch_unexpected_valid", 32'd1, 32'd0);
      else chk("fetch_read_data", fetch_read_data, fq.pop_front());
    end else if (fq.size() != 0) begin
      chk("fetch_missing_valid", 32'd0, 32'd1);
      void'(fq.pop_front());
    end
    if (mem_read_valid) begin
      if (mq.size() == 0) chk("mem_unexpected_valid", 32'd1, 32'd0);
      else chk("mem_read_data", mem_read_data, mq.pop_front());
    end else if (mq.size() != 0) begin
      chk("mem_missing_valid", 32'd0, 32'd1);
      void'(mq.pop_front());
    end
  end

  // One cycle: drive, predict from the arbitration rules, check grants and SPM drive, push expected reads.
  task automatic step(input logic rs, fr, input logic [11:0] fa, input logic mr, mwe,
                      input logic [11:0] ma, input logic [31:0] md, input bit rst_mid = 0);
    reset = rs; fetch_request = fr; fetch_address = fa;
    mem_request = mr; mem_write_enable = mwe; mem_address = ma; mem_write_data = md;
    if (!rs) waited = 0;
    @(negedge clock);
    pmg = rs && mr && !(fr && waited >= MAX);
    pfg = rs && fr && !pmg;
    chk("mem_grant", 32'(mem_grant), 32'(pmg));
    chk("fetch_grant", 32'(fetch_grant), 32'(pfg));
    chk("fetch_stall", 32'(fetch_stall), 32'(rs && fr && !pfg));
    chk("spm_write_enable", 32'(spm_write_enable), 32'(pmg && mwe));
    chk("spm_address", 32'(spm_address), 32'(pmg ? ma : pfg ? fa : 12'd0));
    if (pmg && mwe) chk("spm_write_data", spm_write_data, md);
    if (fetch_stall) stall_cnt++;
    if (rst_mid) begin
      reset = 1'b0;
      #1;
      chk("fetch_grant_in_reset", 32'(fetch_grant), 32'd0);
      chk("mem_grant_in_reset", 32'(mem_grant), 32'd0);
      pfg = 0; pmg = 0;
    end
    if (pfg) fq.push_back(ref_rd(fa));
    if (pmg && !mwe) mq.push_back(ref_rd(ma));
    if (pmg && mwe) ref_mem[int'(ma)] = md;
    waited = (!rs || rst_mid || pfg || !fr) ? 0 : pmg ? waited + 1 : waited;
    @(posedge clock);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic rfr, rmr, rmwe;
  logic [11:0] rfa, rma;
  logic [31:0] rmd;

  initial begin
    reset = 1'b0; fetch_request = 0; fetch_address = 0; mem_request = 0;
    mem_write_enable = 0; mem_address = 0; mem_write_data = 0;
    @(posedge clock); #2;
    // Reset held with both requesting, then release.
    repeat (2) step(0, 1, 12'h005, 1, 1, 12'h006, 32'h1234_5678);
    chk("fetch_valid_in_reset", 32'(fetch_read_valid), 32'd0);
    chk("mem_valid_in_reset", 32'(mem_read_valid), 32'd0);
    step(1, 1, 12'h005, 1, 0, 12'h006, 32'h0);
    step(1, 0, 12'h000, 0, 0, 12'h000, 32'h0);
    // Fetch only, back to back.
    for (int i = 0; i < 3; i++) step(1, 1, 12'(i), 0, 0, 12'h0, 32'h0);
    // Write then read.
    step(1, 0, 12'h0, 1, 1, 12'h010, 32'h0DEADBEE);
    step(1, 0, 12'h0, 1, 0, 12'h010, 32'h0);
    step(1, 0, 12'h0, 0, 0, 12'h0, 32'h0);
    // Starvation bound: M,M,M,F repeating.
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 12'h020 + 12'(i), 1, 0, 12'h030 + 12'(i), 32'h0);
    chk("stall_count_8_cycles", 32'(stall_cnt), 32'd6);
    // Streak clear: fetch 2 cycles, gap, resume; full 3 mem grants again.
    step(1, 0, 12'h0, 0, 0, 12'h0, 32'h0);
    step(1, 1, 12'h040, 1, 0, 12'h050, 32'h0);
    step(1, 1, 12'h040, 1, 0, 12'h051, 32'h0);
    step(1, 0, 12'h040, 1, 0, 12'h052, 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) step(1, 1, 12'h041, 1, 0, 12'h053 + 12'(i), 32'h0);
    chk("stall_after_gap", 32'(stall_cnt), 32'd3);
    // Reset arriving while a fetch read is being granted.
    step(1, 1, 12'h060, 0, 0, 12'h0, 32'h0, 1);
    step(0, 1, 12'h060, 1, 0, 12'h061, 32'h0);
    step(1, 1, 12'h060, 1, 0, 12'h061, 32'h0);
    chk("stall_after_reset", 32'(fetch_stall), 32'd1);
    // Randomized traffic; requests stay stable until granted.
    rfr = 0; rmr = 0; rmwe = 0; rfa = 0; rma = 0; rmd = 0;
    pfg = 0; pmg = 0;
    repeat (400) begin
      if (!rfr || pfg) begin rfr = $urandom_range(0, 3) != 0; rfa = 12'($urandom_range(0, 31)); end
      if (!rmr || pmg) begin
        rmr = 1'($urandom_range(0, 1)); rmwe = 1'($urandom_range(0, 1));
        rma = 12'($urandom_range(0, 31)); rmd = $urandom;
      end
      step(1, rfr, rfa, rmr, rmwe, rma, rmd);
    end
    step(1, 0, 12'h0, 0, 0, 12'h0, 32'h0);
    step(1, 0, 12'h0, 0, 0, 12'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
